cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor 0 for the pipelined MIPS core: holds SR (12), Cause (13) and EPC (14), and decides each cycle whether the instruction in the M stage is replaced by an exception or interrupt entry. It consumes the exception code collected down the pipe, including `Ov` (12) from the E-stage overflow flag, `AdEL`, `AdES`, `Syscall` and `RI`. It also takes the six external hardware interrupt lines. It services `mtc0`, `mfc0` and `eret` at the M stage, and its `req` output drives the pipeline flush and the PC redirect to 0x0000_4180.

## Interface
- No parameters. The handler address 0x0000_4180 is fixed outside this block.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all registers.
- `en`  in  1  `mtc0` write enable (M stage).
- `cp0_addr`  in  5  register number for both `mtc0` and `mfc0`.
- `cp0_in`  in  32  `mtc0` write data (rt value).
- `cp0_out`  out  32  `mfc0` read data; combinational.
- `vpc`  in  32  PC of the M-stage instruction (the victim).
- `bd_in`  in  1  M-stage instruction sits in a branch delay slot.
- `exc_code_in`  in  5  pending exception code; 0 means none.
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `exl_clr`  in  1  `eret` present in the M stage.
- `epc_out`  out  32  current EPC register value; `eret` target.
- `req`  out  1  take exception or interrupt this cycle; combinational.

## Operation
- **SR fields:**
  - IM[15:10], EXL[1] and IE[0] are storage bits.
  - All other bits read 0 and ignore writes.
- **Cause fields:**
  - BD[31], IP[15:10] and ExcCode[6:2] are defined; all other bits read 0.
  - Cause is read-only to software: `mtc0` to register 13 is ignored.
- **EPC:** 32-bit, written in full by `mtc0`.
- **Interrupt request:** `int_req = IE & ~EXL & |(hw_int & IM)`.
- **Exception request:** `exc_req = (exc_code_in != 0) & ~EXL`.
- **`req`:** `req = int_req | exc_req`. Interrupt has priority over exception.
- **On `req`, at the next edge:**
  - EXL <= 1.
  - Cause.BD <= `bd_in`.
  - Cause.ExcCode <= 0 when `int_req`, otherwise `exc_code_in`.
  - EPC <= `bd_in` ? {`vpc`[31:2],2'b00} − 4 : {`vpc`[31:2],2'b00}.
- **Cause.IP:** IP <= `hw_int` every cycle, whether or not `req` is asserted (IP sampled, not latched-sticky).
- **Write priority for EXL:** `req` > `exl_clr` > `mtc0`.
  - `exl_clr` sets EXL <= 0 unless `req` is asserted in the same cycle.
- **Writes during `req`:** an `mtc0` (`en`=1) in the same cycle as `req` is discarded entirely, because the faulting or interrupted instruction does not commit.
- **`mfc0` reads:**
  - `cp0_out` returns the register selected by `cp0_addr` from current state, with no bypass of a same-cycle write.
  - Addresses other than 12, 13 and 14 read 0.
- **Register values are never forwarded:**
  - `epc_out` is the register value only.
  - The hazard unit stalls `eret` in D while an `mtc0` to EPC is in E or M.

## Timing
- **Reset:** SR, Cause and EPC are all 0, so `req`=0, `cp0_out`=0 and `epc_out`=0.
- **Latency:**
  - `req` is combinational, same cycle as its inputs.
  - Register effects are visible one cycle after the edge.
- **Register updates:**
  - An `mtc0` commits at the edge ending its M cycle.
  - A `mfc0` in the following cycle sees the new value.
- **Reset vs `req`:** `reset` asserted in the same cycle as `req` wins, and all state goes to 0.
- **Handler masking:** while EXL=1, `req` stays 0 regardless of `hw_int` or `exc_code_in`. This blocks nested entry until `eret`.
- **`hw_int` timing:** `hw_int` is registered by the bridge upstream; this block adds no synchronizer.

## Test plan
- **Overflow entry:**
  - Stimulus: reset; SR<-0x0000_0C01; `exc_code_in`=12, `vpc`=0x3008, `bd_in`=0.
  - Required: `req`=1 same cycle.
  - Next cycle: EPC=0x3008, Cause=0x0000_0030, SR=0x0000_0C03.
- **Delay-slot fault:**
  - Stimulus: `exc_code_in`=4, `vpc`=0x3010, `bd_in`=1.
  - Required: EPC=0x300C, Cause=0x8000_0010.
- **Interrupt priority and IP:**
  - Stimulus: SR=0x0000_0401, `hw_int`=6'b000001, `exc_code_in`=10 in the same cycle.
  - Required: `req`=1; Cause.ExcCode=0; Cause.IP=0x0400 field, i.e. Cause=0x0000_0400.
- **Masking:**
  - Stimulus: IE=0, or EXL=1, or IM=0, with `hw_int`=6'b111111.
  - Required: `req`=0 in every case.
  - With EXL=1 and `exc_code_in`=8: `req`=0.
- **`eret` and write-discard:**
  - Stimulus: `exl_clr`=1 with EXL=1.
  - Required: EXL=0 next cycle.
  - Stimulus: `en`=1, `cp0_addr`=14, `cp0_in`=0x1234 concurrent with `req`.
  - Required: EPC takes the victim PC, not 0x1234.
- **Reset mid-operation:**
  - Stimulus: assert `reset` in the same cycle as `req`.
  - Required: all registers 0 next cycle; `cp0_out` for addresses 12, 13 and 14 reads 0.

Source files
------------

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 holding SR (12), Cause (13) and EPC (14).
// It decides each cycle whether the M-stage instruction is replaced by an
// exception or interrupt entry, and services mtc0 / mfc0 / eret at M.
module cp0_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic [31:0] epc_out,
    output logic        req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    // SR storage bits
    logic [5:0]  im_reg,  im_next;
    logic        exl_reg, exl_next;
    logic        ie_reg,  ie_next;
    // Cause storage bits
    logic        bd_reg,  bd_next;
    logic [5:0]  ip_reg,  ip_next;
    logic [4:0]  exc_code_reg, exc_code_next;
    // EPC
    logic [31:0] epc_reg, epc_next;

    logic [5:0]  pending;
    logic        int_req;
    logic        exc_req;
    logic        sr_wr;
    logic        epc_wr;
    logic [31:0] victim_pc;
    logic [31:0] entry_epc;
    logic [31:0] sr_value;
    logic [31:0] cause_value;

    // Per-line qualification of the external interrupt inputs by the IM mask
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi = gi + 1) begin : g_pending
            assign pending[gi] = hw_int[gi] & im_reg[gi];
        end
    endgenerate

    // Entry decision: interrupts only when enabled and not already in a
    // handler; exceptions whenever a code is pending outside a handler.
    always_comb begin
        int_req = ie_reg & ~exl_reg & (|pending);
        exc_req = (exc_code_in != 5'd0) & ~exl_reg;
        req     = int_req | exc_req;
    end

    // EPC target: the victim's word address, backed up one instruction when
    // the victim sits in a delay slot so the branch is re-executed.
    always_comb begin
        victim_pc = {vpc[31:2], 2'b00};
        entry_epc = bd_in ? (victim_pc - 32'd4) : victim_pc;
    end

    // Architectural views of SR and Cause; unimplemented bits read zero
    always_comb begin
        sr_value    = {16'h0000, im_reg, 8'h00, exl_reg, ie_reg};
        cause_value = {bd_reg, 15'h0000, ip_reg, 3'b000, exc_code_reg, 2'b00};
    end

    // mfc0 read mux from current register state (no same-cycle bypass)
    always_comb begin
        case (cp0_addr)
            ADDR_SR:    cp0_out = sr_value;
            ADDR_CAUSE: cp0_out = cause_value;
            ADDR_EPC:   cp0_out = epc_reg;
            default:    cp0_out = 32'h0000_0000;
        endcase
        epc_out = epc_reg;
    end

    // Software write decode; Cause is read-only so it has no write strobe
    always_comb begin
        sr_wr  = en & (cp0_addr == ADDR_SR);
        epc_wr = en & (cp0_addr == ADDR_EPC);
    end

    // Next-state: entry beats eret beats mtc0; an mtc0 in an entry cycle
    // belongs to the instruction being cancelled and is dropped entirely.
    always_comb begin
        im_next       = im_reg;
        exl_next      = exl_reg;
        ie_next       = ie_reg;
        bd_next       = bd_reg;
        ip_next       = hw_int;
        exc_code_next = exc_code_reg;
        epc_next      = epc_reg;
        if (req) begin
            exl_next      = 1'b1;
            bd_next       = bd_in;
            exc_code_next = int_req ? 5'd0 : exc_code_in;
            epc_next      = entry_epc;
        end else begin
            if (sr_wr) begin
                im_next  = cp0_in[15:10];
                exl_next = cp0_in[1];
                ie_next  = cp0_in[0];
            end
            if (exl_clr) begin
                exl_next = 1'b0;
            end
            if (epc_wr) begin
                epc_next = cp0_in;
            end
        end
    end

    // State registers with synchronous reset taking precedence over entry
    always_ff @(posedge clk) begin
        if (reset) begin
            im_reg       <= 6'd0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_reg       <= 6'd0;
            exc_code_reg <= 5'd0;
            epc_reg      <= 32'd0;
        end else begin
            im_reg       <= im_next;
            exl_reg      <= exl_next;
            ie_reg       <= ie_next;
            bd_reg       <= bd_next;
            ip_reg       <= ip_next;
            exc_code_reg <= exc_code_next;
            epc_reg      <= epc_next;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: table-driven request checks, hand-written corner sequences,
// and a randomized run against a word-level model of SR/Cause/EPC.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] epc_out;
    logic        req;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_in      (cp0_in),
        .cp0_out     (cp0_out),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .exl_clr     (exl_clr),
        .epc_out     (epc_out),
        .req         (req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sr;
        logic [5:0]  hw;
        logic [4:0]  code;
        logic        exp_req;
    } vec_t;

    vec_t vecs [0:9];

    // Word-level reference model
    logic [31:0] m_sr, m_cause, m_epc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic idle_inputs();
        en = 1'b0; cp0_addr = 5'd0; cp0_in = 32'd0; vpc = 32'd0; bd_in = 1'b0;
        exc_code_in = 5'd0; hw_int = 6'd0; exl_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en = 1'b1; cp0_addr = a; cp0_in = d;
        tick();
        en = 1'b0; cp0_in = 32'd0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(name, cp0_out, exp);
    endtask

    function automatic logic model_int();
        logic [5:0] im;
        im = m_sr[15:10];
        return m_sr[0] & ~m_sr[1] & (|(hw_int & im));
    endfunction

    function automatic logic model_req();
        return model_int() | ((exc_code_in != 5'd0) & ~m_sr[1]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd12) return m_sr;
        if (a == 5'd13) return m_cause;
        if (a == 5'd14) return m_epc;
        return 32'd0;
    endfunction

    // Apply one clock edge of architectural rules to the model
    task automatic model_step();
        logic [31:0] pc;
        logic r, ir;
        r  = model_req();
        ir = model_int();
        pc = vpc & 32'hFFFF_FFFC;
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else if (r) begin
            m_sr    = m_sr | 32'h2;
            m_cause = ({31'd0, bd_in} << 31) | ({26'd0, hw_int} << 10)
                    | (ir ? 32'd0 : ({27'd0, exc_code_in} << 2));
            m_epc   = bd_in ? pc - 4 : pc;
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
            if (en && cp0_addr == 5'd12) m_sr = cp0_in & 32'h0000_FC03;
            if (exl_clr) m_sr = m_sr & ~32'h2;
            if (en && cp0_addr == 5'd14) m_epc = cp0_in;
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        vecs[0] = '{32'h0000_FC00, 6'h3F, 5'd0, 1'b0};  // IE=0
        vecs[1] = '{32'h0000_FC03, 6'h3F, 5'd0, 1'b0};  // EXL=1
        vecs[2] = '{32'h0000_0001, 6'h3F, 5'd0, 1'b0};  // IM=0
        vecs[3] = '{32'h0000_0002, 6'h00, 5'd8, 1'b0};  // EXL masks exception
        vecs[4] = '{32'h0000_FC01, 6'h3F, 5'd0, 1'b1};
        vecs[5] = '{32'h0000_0401, 6'h01, 5'd0, 1'b1};
        vecs[6] = '{32'h0000_0801, 6'h01, 5'd0, 1'b0};  // wrong IM line
        vecs[7] = '{32'h0000_0000, 6'h00, 5'd8, 1'b1};
        vecs[8] = '{32'h0000_8001, 6'h20, 5'd0, 1'b1};
        vecs[9] = '{32'h0000_0000, 6'h00, 5'd0, 1'b0};
        @(posedge clk); #1;

        // Reset state
        do_reset();
        read_chk("reset_sr", 5'd12, 32'h0);
        read_chk("reset_cause", 5'd13, 32'h0);
        read_chk("reset_epc", 5'd14, 32'h0);
        check("reset_req", {31'd0, req}, 32'h0);

        // Request table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            mtc0(5'd12, vecs[i].sr);
            hw_int = vecs[i].hw; exc_code_in = vecs[i].code;
            #1;
            check($sformatf("table_req[%0d]", i), {31'd0, req}, {31'd0, vecs[i].exp_req});
            idle_inputs();
        end

        // Write masks: SR keeps only storage bits, Cause ignores mtc0
        do_reset();
        mtc0(5'd12, 32'hFFFF_FFFF);
        read_chk("sr_mask", 5'd12, 32'h0000_FC03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        read_chk("cause_ro", 5'd13, 32'h0);
        read_chk("unmapped_addr", 5'd15, 32'h0);

        // Overflow entry
        do_reset();
        mtc0(5'd12, 32'h0000_0C01);
        exc_code_in = 5'd12; vpc = 32'h3008; bd_in = 1'b0;
        #1;
        check("ov_req", {31'd0, req}, 32'h1);
        tick();
        idle_inputs();
        check("ov_epc_out", epc_out, 32'h3008);
        read_chk("ov_epc", 5'd14, 32'h3008);
        read_chk("ov_cause", 5'd13, 32'h0000_0030);
        read_chk("ov_sr", 5'd12, 32'h0000_0C03);
        exc_code_in = 5'd8;
        #1;
        check("exl_masks_exc", {31'd0, req}, 32'h0);
        exc_code_in = 5'd0;

        // Delay-slot fault
        do_reset();
        exc_code_in = 5'd4; vpc = 32'h3010; bd_in = 1'b1;
        tick();
        idle_inputs();
        read_chk("bd_epc", 5'd14, 32'h300C);
        read_chk("bd_cause", 5'd13, 32'h8000_0010);

        // Interrupt priority over a concurrent exception, IP sampling
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_code_in = 5'd10; vpc = 32'h3040;
        #1;
        check("int_req", {31'd0, req}, 32'h1);
        tick();
        exc_code_in = 5'd0;
        read_chk("int_cause", 5'd13, 32'h0000_0400);
        read_chk("int_epc", 5'd14, 32'h3040);

        // eret clears EXL
        hw_int = 6'd0;
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        read_chk("eret_sr", 5'd12, 32'h0000_0401);

        // mtc0 to EPC concurrent with an entry is discarded
        exc_code_in = 5'd8; vpc = 32'h3020;
        en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'h1234;
        #1;
        check("discard_req", {31'd0, req}, 32'h1);
        tick();
        idle_inputs();
        check("discard_epc", epc_out, 32'h3020);

        // Reset wins over a same-cycle entry
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        exc_code_in = 5'd12; vpc = 32'h3100; bd_in = 1'b1;
        #1;
        check("rst_pre_req", {31'd0, req}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        read_chk("rst_sr", 5'd12, 32'h0);
        read_chk("rst_cause", 5'd13, 32'h0);
        read_chk("rst_epc", 5'd14, 32'h0);

        // Randomized run against the model
        do_reset();
        m_sr = 0; m_cause = 0; m_epc = 0;
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom % 100) == 0;
            en          = ($urandom % 4) == 0;
            case ($urandom % 4)
                0: cp0_addr = 5'd12;
                1: cp0_addr = 5'd13;
                2: cp0_addr = 5'd14;
                default: cp0_addr = 5'($urandom);
            endcase
            cp0_in      = $urandom;
            vpc         = $urandom;
            bd_in       = 1'($urandom);
            exc_code_in = (($urandom % 6) == 0) ? 5'($urandom) : 5'd0;
            hw_int      = (($urandom % 3) == 0) ? 6'($urandom) : 6'd0;
            exl_clr     = ($urandom % 5) == 0;
            #1;
            if (req !== model_req()) begin
                n_cmp++; n_bad++;
                $display("FAIL rand_req[%0d]: got %0b expected %0b", c, req, model_req());
            end else n_cmp++;
            if (cp0_out !== model_read(cp0_addr)) begin
                n_cmp++; n_bad++;
                $display("FAIL rand_cp0_out[%0d] addr %0d: got 0x%08h expected 0x%08h",
                         c, cp0_addr, cp0_out, model_read(cp0_addr));
            end else n_cmp++;
            if (epc_out !== m_epc) begin
                n_cmp++; n_bad++;
                $display("FAIL rand_epc[%0d]: got 0x%08h expected 0x%08h", c, epc_out, m_epc);
            end else n_cmp++;
            @(posedge clk);
            model_step();
            #1;
        end
        reset = 1'b0;
        $display("random phase: 3000 cycles, running totals %0d/%0d", n_cmp, n_bad);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
